aud_transport_ctrl: RTL and testbench

Parametrised transport controller for the audio subsystem. It sequences codec initialisation, then record/pause/play/pause/stop per push-button pulse. It generates SRAM addresses for one of `SLOTS` independent recording slots and keeps a per-slot length table, so playback stops (or loops) at the recorded end. It sits between the key debouncers, the codec initialiser handshake, the SRAM interface and the sample-rate strobe.

---
 rtl/aud_transport_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_aud_transport_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aud_transport_ctrl.sv
// aud_transport_ctrl
// Transport controller for the audio subsystem: waits for codec initialisation,
// then sequences record / record-pause / play / play-pause / stop from one-cycle
// key pulses. It generates SRAM word addresses {slot, offset} for one of SLOTS
// recording slots and keeps a per-slot length table so playback ends (or loops)
// at the recorded end.
//
// Ports
//   i_clk, i_rst                     clock, synchronous active-high reset
//   i_key_rec/play/stop              debounced one-cycle key pulses
//   i_slot                           slot select, sampled on record/play start
//   i_loop                           loop-play mode, sampled at end of slot
//   i_sample_tick                    one-cycle strobe per audio sample
//   i_init_done                      codec initialiser finished
//   o_init_start                     request codec initialisation (registered)
//   o_state                          current state code (registered)
//   o_sram_addr                      {slot, offset} (registered)
//   o_sram_we, o_play_tick           per-sample write / consume strobes (comb)
//   o_rec_en, o_play_en              recorder / player enables (registered)
//   o_full, o_done                   end-of-slot event pulses (comb)
//   o_slot_len                       length entry of the active slot (registered)
//
// state        | meaning
// S_IDLE  (0)  | stopped, waiting for rec/play
// S_INIT  (1)  | codec initialisation requested, keys ignored
// S_RECD  (2)  | recording, one word written per sample tick
// S_RECD_PAUSE | recording paused, offset and length held
// S_PLAY  (4)  | playing, one word consumed per sample tick
// S_PLAY_PAUSE | playback paused, offset held

module aud_transport_ctrl #(
    parameter int ADDR_W = 20,
    parameter int SLOTS  = 4,
    localparam int SEL_W = $clog2(SLOTS),
    localparam int OFF_W = ADDR_W - SEL_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_key_rec,
    input  logic              i_key_play,
    input  logic              i_key_stop,
    input  logic [SEL_W-1:0]  i_slot,
    input  logic              i_loop,
    input  logic              i_sample_tick,
    input  logic              i_init_done,
    output logic              o_init_start,
    output logic [2:0]        o_state,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic              o_sram_we,
    output logic              o_rec_en,
    output logic              o_play_en,
    output logic              o_play_tick,
    output logic              o_full,
    output logic              o_done,
    output logic [OFF_W:0]    o_slot_len
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_INIT       = 3'd1,
        S_RECD       = 3'd2,
        S_RECD_PAUSE = 3'd3,
        S_PLAY       = 3'd4,
        S_PLAY_PAUSE = 3'd5
    } state_t;

    state_t             r_state;
    logic [SEL_W-1:0]   r_slot;
    logic [OFF_W-1:0]   r_off;
    logic [OFF_W:0]     r_len [SLOTS];
    logic               r_init_start;
    logic               r_rec_en;
    logic               r_play_en;
    logic [OFF_W:0]     r_slot_len;

    state_t             w_state_nxt;
    logic [SEL_W-1:0]   w_slot_nxt;
    logic [OFF_W-1:0]   w_off_nxt;
    logic               w_len_we;
    logic [SEL_W-1:0]   w_len_idx;
    logic [OFF_W:0]     w_len_val;
    logic [OFF_W:0]     w_slot_len_nxt;
    logic [OFF_W:0]     w_off_inc;

    // One bit wider than the offset so a full slot's length (2^OFF_W) fits.
    assign w_off_inc = {1'b0, r_off} + (OFF_W+1)'(1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_INIT;
            r_slot       <= '0;
            r_off        <= '0;
            for (int i = 0; i < SLOTS; i++) r_len[i] <= '0;
            r_init_start <= 1'b1;
            r_rec_en     <= 1'b0;
            r_play_en    <= 1'b0;
            r_slot_len   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_slot       <= w_slot_nxt;
            r_off        <= w_off_nxt;
            for (int i = 0; i < SLOTS; i++) begin
                if (w_len_we && (w_len_idx == SEL_W'(i))) r_len[i] <= w_len_val;
            end
            r_init_start <= (w_state_nxt == S_INIT);
            r_rec_en     <= (w_state_nxt == S_RECD);
            r_play_en    <= (w_state_nxt == S_PLAY);
            r_slot_len   <= w_slot_len_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_slot_nxt  = r_slot;
        w_off_nxt   = r_off;
        w_len_we    = 1'b0;
        w_len_idx   = r_slot;
        w_len_val   = w_off_inc;
        case (r_state)
            S_INIT: begin
                if (i_init_done) w_state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (i_key_stop) begin
                    w_state_nxt = S_IDLE;
                end else if (i_key_rec) begin
                    w_state_nxt = S_RECD;
                    w_slot_nxt  = i_slot;
                    w_off_nxt   = '0;
                    w_len_we    = 1'b1;
                    w_len_idx   = i_slot;
                    w_len_val   = '0;
                end else if (i_key_play && (r_len[i_slot] != '0)) begin
                    w_state_nxt = S_PLAY;
                    w_slot_nxt  = i_slot;
                    w_off_nxt   = '0;
                end
            end
            S_RECD: begin
                if (i_sample_tick) begin
                    w_len_we  = 1'b1;
                    w_off_nxt = w_off_inc[OFF_W-1:0];
                end
                if (i_key_stop || o_full) w_state_nxt = S_IDLE;
                else if (i_key_rec)       w_state_nxt = S_RECD_PAUSE;
            end
            S_RECD_PAUSE: begin
                if (i_key_stop)     w_state_nxt = S_IDLE;
                else if (i_key_rec) w_state_nxt = S_RECD;
            end
            S_PLAY: begin
                if (i_sample_tick) w_off_nxt = o_done ? '0 : w_off_inc[OFF_W-1:0];
                if (i_key_stop || (o_done && !i_loop)) w_state_nxt = S_IDLE;
                else if (i_key_play)                   w_state_nxt = S_PLAY_PAUSE;
            end
            S_PLAY_PAUSE: begin
                if (i_key_stop)      w_state_nxt = S_IDLE;
                else if (i_key_play) w_state_nxt = S_PLAY;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_state_nxt == S_IDLE) w_off_nxt = '0;
        // Registered length output follows the table as it will be after this edge.
        w_slot_len_nxt = (w_len_we && (w_len_idx == w_slot_nxt)) ? w_len_val : r_len[w_slot_nxt];
    end

    always_comb begin
        o_sram_we   = (r_state == S_RECD) && i_sample_tick;
        o_play_tick = (r_state == S_PLAY) && i_sample_tick;
        o_full      = o_sram_we && (&r_off);
        o_done      = o_play_tick && (w_off_inc == r_len[r_slot]);
    end

    assign o_state      = r_state;
    assign o_sram_addr  = {r_slot, r_off};
    assign o_init_start = r_init_start;
    assign o_rec_en     = r_rec_en;
    assign o_play_en    = r_play_en;
    assign o_slot_len   = r_slot_len;

endmodule

// File: tb/tb_aud_transport_ctrl.sv
module tb_aud_transport_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_rec = 1'b0, key_play = 1'b0, key_stop = 1'b0;
    logic [1:0] slot = 2'd0;
    logic       loop_m = 1'b0;
    logic       tick = 1'b0;
    logic       init_done = 1'b0;

    always #5 clk = ~clk;

    // Two configurations driven by the same stimulus.
    logic        b_init, b_we, b_ren, b_pen, b_pt, b_full, b_done;
    logic [2:0]  b_state;
    logic [19:0] b_addr;
    logic [18:0] b_len;
    logic        s_init, s_we, s_ren, s_pen, s_pt, s_full, s_done;
    logic [2:0]  s_state;
    logic [5:0]  s_addr;
    logic [4:0]  s_len;

    aud_transport_ctrl #(.ADDR_W(20), .SLOTS(4)) u_big (
        .i_clk(clk), .i_rst(rst), .i_key_rec(key_rec), .i_key_play(key_play),
        .i_key_stop(key_stop), .i_slot(slot), .i_loop(loop_m), .i_sample_tick(tick),
        .i_init_done(init_done), .o_init_start(b_init), .o_state(b_state),
        .o_sram_addr(b_addr), .o_sram_we(b_we), .o_rec_en(b_ren), .o_play_en(b_pen),
        .o_play_tick(b_pt), .o_full(b_full), .o_done(b_done), .o_slot_len(b_len));

    aud_transport_ctrl #(.ADDR_W(6), .SLOTS(4)) u_small (
        .i_clk(clk), .i_rst(rst), .i_key_rec(key_rec), .i_key_play(key_play),
        .i_key_stop(key_stop), .i_slot(slot), .i_loop(loop_m), .i_sample_tick(tick),
        .i_init_done(init_done), .o_init_start(s_init), .o_state(s_state),
        .o_sram_addr(s_addr), .o_sram_we(s_we), .o_rec_en(s_ren), .o_play_en(s_pen),
        .o_play_tick(s_pt), .o_full(s_full), .o_done(s_done), .o_slot_len(s_len));

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: state code, slot, offset, length table per configuration.
    int ow [2] = '{18, 4};
    int m_st [2];
    int m_slot [2];
    int m_off [2];
    int m_len [2][4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k] = 1; m_slot[k] = 0; m_off[k] = 0;
            for (int j = 0; j < 4; j++) m_len[k][j] = 0;
        end
    endtask

    task automatic check_inst(input int k, input string nm,
                              input logic [31:0] st, input logic [31:0] addr,
                              input logic [31:0] len, input logic init, input logic we,
                              input logic ren, input logic pen, input logic pt,
                              input logic full, input logic done);
        int mx;
        bit ewe, ept;
        mx  = (1 << ow[k]) - 1;
        ewe = (m_st[k] == 2) && tick;
        ept = (m_st[k] == 4) && tick;
        chk({nm, ".state"},      st,   m_st[k]);
        chk({nm, ".addr"},       addr, (m_slot[k] << ow[k]) | m_off[k]);
        chk({nm, ".slot_len"},   len,  m_len[k][m_slot[k]]);
        chk({nm, ".init_start"}, {31'd0, init}, {31'd0, m_st[k] == 1});
        chk({nm, ".rec_en"},     {31'd0, ren},  {31'd0, m_st[k] == 2});
        chk({nm, ".play_en"},    {31'd0, pen},  {31'd0, m_st[k] == 4});
        chk({nm, ".sram_we"},    {31'd0, we},   {31'd0, ewe});
        chk({nm, ".play_tick"},  {31'd0, pt},   {31'd0, ept});
        chk({nm, ".full"},       {31'd0, full}, {31'd0, ewe && (m_off[k] == mx)});
        chk({nm, ".done"},       {31'd0, done},
            {31'd0, ept && (m_off[k] + 1 == m_len[k][m_slot[k]])});
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int mx, st, sl, off;
            bit full, fin;
            mx = (1 << ow[k]) - 1;
            st = m_st[k]; sl = m_slot[k]; off = m_off[k];
            full = 0; fin = 0;
            if (rst) begin
                st = 1; sl = 0; off = 0;
                for (int j = 0; j < 4; j++) m_len[k][j] = 0;
            end else begin
                case (st)
                    1: if (init_done) st = 0;
                    0: begin
                        if (key_stop) st = 0;
                        else if (key_rec) begin
                            st = 2; sl = slot; off = 0; m_len[k][sl] = 0;
                        end else if (key_play && m_len[k][slot] != 0) begin
                            st = 4; sl = slot; off = 0;
                        end
                    end
                    2: begin
                        if (tick) begin
                            m_len[k][sl] = off + 1;
                            full = (off == mx);
                            off = off + 1;
                        end
                        if (key_stop || full) st = 0;
                        else if (key_rec) st = 3;
                    end
                    3: if (key_stop) st = 0; else if (key_rec) st = 2;
                    4: begin
                        if (tick) begin
                            if (off + 1 == m_len[k][sl]) begin
                                if (loop_m) off = 0; else fin = 1;
                            end else off = off + 1;
                        end
                        if (key_stop || fin) st = 0;
                        else if (key_play) st = 5;
                    end
                    5: if (key_stop) st = 0; else if (key_play) st = 4;
                    default: st = 0;
                endcase
            end
            if (st == 0) off = 0;
            m_st[k] = st; m_slot[k] = sl; m_off[k] = off;
        end
    endtask

    // Inputs are set just after a falling edge; outputs are checked 1 ns later.
    task automatic step();
        #1;
        check_inst(0, "big", 32'(b_state), 32'(b_addr), 32'(b_len), b_init, b_we,
                   b_ren, b_pen, b_pt, b_full, b_done);
        check_inst(1, "small", 32'(s_state), 32'(s_addr), 32'(s_len), s_init, s_we,
                   s_ren, s_pen, s_pt, s_full, s_done);
        model_step();
        @(negedge clk);
    endtask

    task automatic drive(input bit r, input bit p, input bit s, input bit t);
        key_rec = r; key_play = p; key_stop = s; tick = t;
        step();
        key_rec = 0; key_play = 0; key_stop = 0; tick = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0);
    endtask

    task automatic init_seq();
        init_done = 1'b1; drive(0, 0, 0, 0); init_done = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        model_reset();
        drive(0, 0, 0, 0);
        rst = 1'b0;
        // Initialisation wait with a rec key that must be ignored.
        for (int i = 0; i < 10; i++) drive(i == 3, 0, 0, 0);
        init_seq();
        chk("idle_after_init", 32'(b_state), 0);

        // Record 5 samples into slot 2.
        slot = 2'd2;
        drive(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin drive(0, 0, 0, 1); idle(2); end
        drive(0, 0, 1, 0);
        chk("rec5_len_big", 32'(b_len), 5);
        chk("rec5_len_small", 32'(s_len), 5);

        // Play once, then looped.
        loop_m = 1'b0;
        drive(0, 1, 0, 0);
        for (int i = 0; i < 7; i++) begin drive(0, 0, 0, 1); idle(1); end
        chk("play_end_idle", 32'(b_state), 0);
        loop_m = 1'b1;
        drive(0, 1, 0, 0);
        for (int i = 0; i < 7; i++) begin drive(0, 0, 0, 1); idle(1); end
        chk("loop_still_play", 32'(b_state), 4);
        chk("loop_addr", 32'(b_addr), 32'h80002);
        drive(0, 0, 1, 0);
        loop_m = 1'b0;

        // Continuous recording into slot 1: small config fills at 16.
        slot = 2'd1;
        drive(1, 0, 0, 0);
        for (int i = 0; i < 20; i++) drive(0, 0, 0, 1);
        chk("full_len_small", 32'(s_len), 16);
        chk("full_idle_small", 32'(s_state), 0);
        drive(0, 0, 1, 0);
        chk("len20_big", 32'(b_len), 20);

        // Record with pauses into slot 0.
        slot = 2'd0;
        drive(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 1);
        drive(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 1);
        drive(0, 1, 0, 0);
        drive(1, 0, 0, 0);
        for (int i = 0; i < 2; i++) drive(0, 0, 0, 1);
        drive(0, 0, 1, 0);
        chk("pause_len", 32'(b_len), 5);

        // Play an empty slot.
        slot = 2'd3;
        drive(0, 1, 0, 0);
        chk("empty_play_idle", 32'(b_state), 0);

        // Tick coincident with stop while recording slot 3.
        drive(1, 0, 0, 0);
        drive(0, 0, 0, 1);
        drive(0, 0, 1, 1);
        chk("tick_stop_len", 32'(b_len), 2);

        // All keys together in idle.
        drive(1, 1, 1, 0);
        chk("all_keys_idle", 32'(b_state), 0);

        // Reset in the middle of playback.
        slot = 2'd2;
        drive(0, 1, 0, 0);
        drive(0, 0, 0, 1);
        rst = 1'b1; drive(0, 0, 0, 1); rst = 1'b0;
        chk("rst_state", 32'(b_state), 1);
        chk("rst_len", 32'(b_len), 0);
        idle(2);
        init_seq();
        drive(0, 1, 0, 0);
        chk("cleared_play_idle", 32'(b_state), 0);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            slot      = 2'($urandom_range(0, 3));
            loop_m    = 1'($urandom_range(0, 1));
            init_done = ($urandom_range(0, 3) == 0);
            rst       = ($urandom_range(0, 1499) == 0);
            drive($urandom_range(0, 14) == 0, $urandom_range(0, 11) == 0,
                  $urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0);
        end
        rst = 1'b0; init_done = 1'b0;
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
